// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared types and constants for the fetch-stage stall/redirect sequencer.
package hazard_stall_ctrl_pkg;

   localparam int         COMMON_WIDTH    = 32;
   localparam logic [4:0] REG_ZERO        = 5'd0;
   localparam int         MD_LATENCY_DEF  = 32;
   localparam int         MEM_TIMEOUT_DEF = 255;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_MD_WAIT  = 2'd1,
      ST_MEM_WAIT = 2'd2
   } state_e;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Pipeline-side bundle: hazard sources from ID/EX/MEM in, stall/redirect controls out.
interface hazard_stall_ctrl_if;
   import hazard_stall_ctrl_pkg::*;

   logic [4:0]              id_rs1_addr;
   logic [4:0]              id_rs2_addr;
   logic                    id_rs1_rd;
   logic                    id_rs2_rd;
   logic                    ex_load;
   logic [4:0]              ex_rd_addr;
   logic                    ex_jump_req;
   logic [COMMON_WIDTH-1:0] ex_jump_addr;
   logic                    md_start;
   logic                    mem_req;
   logic                    mem_ack;

   logic                    jump_en;
   logic [COMMON_WIDTH-1:0] jump_addr;
   logic                    jump_stall;
   logic                    full_stall;
   logic                    idex_bubble;
   logic                    ifid_flush;
   logic                    mem_timeout;
   logic [31:0]             stall_cycles;

   modport master (
      output id_rs1_addr, id_rs2_addr, id_rs1_rd, id_rs2_rd,
             ex_load, ex_rd_addr, ex_jump_req, ex_jump_addr,
             md_start, mem_req, mem_ack,
      input  jump_en, jump_addr, jump_stall, full_stall,
             idex_bubble, ifid_flush, mem_timeout, stall_cycles
   );

   modport slave (
      input  id_rs1_addr, id_rs2_addr, id_rs1_rd, id_rs2_rd,
             ex_load, ex_rd_addr, ex_jump_req, ex_jump_addr,
             md_start, mem_req, mem_ack,
      output jump_en, jump_addr, jump_stall, full_stall,
             idex_bubble, ifid_flush, mem_timeout, stall_cycles
   );

endinterface

// File: rtl/hazard_stall_ctrl_hazard_detect.sv
// Load-use compare: the ID instruction reads a register that the EX load is about to write.
module hazard_detect
   import hazard_stall_ctrl_pkg::*;
(
   input  logic [4:0] id_rs1_addr,
   input  logic [4:0] id_rs2_addr,
   input  logic       id_rs1_rd,
   input  logic       id_rs2_rd,
   input  logic       ex_load,
   input  logic [4:0] ex_rd_addr,
   output logic       load_use
);

   logic rs1_hit;
   logic rs2_hit;

   // x0 is hardwired to zero, so a load targeting it never creates a dependency.
   assign rs1_hit  = id_rs1_rd && (id_rs1_addr == ex_rd_addr);
   assign rs2_hit  = id_rs2_rd && (id_rs2_addr == ex_rd_addr);
   assign load_use = ex_load && (ex_rd_addr != REG_ZERO) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Stall/redirect sequencer: load-use bubbles, EX jumps, fixed-latency mul/div and
// handshaked data-memory waits with a watchdog. Priority: full_stall > jump > load_use.
module hazard_stall_ctrl
   import hazard_stall_ctrl_pkg::*;
#(
   parameter int MD_LATENCY  = MD_LATENCY_DEF,
   parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
   input  logic               clk,
   input  logic               rst,
   hazard_stall_ctrl_if.slave bus
);

   localparam int MD_CNT_W = (MD_LATENCY > 1) ? $clog2(MD_LATENCY) : 1;
   localparam int CNT_W    = max_int(8, MD_CNT_W);
   localparam bit MD_MULTI = (MD_LATENCY > 1);

   localparam logic [CNT_W-1:0] MD_RELOAD = CNT_W'(MD_MULTI ? (MD_LATENCY - 2) : 0);
   localparam logic [CNT_W-1:0] MEM_LAST  = CNT_W'(MEM_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   state_e      state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic        md_pend_q, md_pend_d;
   logic        mem_timeout_q, mem_timeout_d;
   logic [31:0] stall_cycles_q, stall_cycles_d;

   logic load_use;
   logic stall_raw;
   logic full_stall;
   logic jump_en;
   logic jump_stall;

   hazard_detect u_hazard_detect (
      .id_rs1_addr (bus.id_rs1_addr),
      .id_rs2_addr (bus.id_rs2_addr),
      .id_rs1_rd   (bus.id_rs1_rd),
      .id_rs2_rd   (bus.id_rs2_rd),
      .ex_load     (bus.ex_load),
      .ex_rd_addr  (bus.ex_rd_addr),
      .load_use    (load_use)
   );

   // NOTE: every variable gets its hold value first so no path through the case infers a latch.
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      md_pend_d     = md_pend_q;
      mem_timeout_d = mem_timeout_q;
      stall_raw     = 1'b0;

      unique case (state_q)
         ST_RUN: begin
            stall_raw = (bus.mem_req && !bus.mem_ack) || bus.md_start;
            if (bus.mem_req && !bus.mem_ack) begin
               // A coincident mul/div launch waits behind the memory access.
               state_d   = ST_MEM_WAIT;
               cnt_d     = '0;
               md_pend_d = bus.md_start;
            end else if (bus.md_start && MD_MULTI) begin
               state_d = ST_MD_WAIT;
               cnt_d   = MD_RELOAD;
            end
         end

         ST_MD_WAIT: begin
            stall_raw = 1'b1;
            if (cnt_q == '0) state_d = ST_RUN;
            else             cnt_d   = cnt_q - CNT_ONE;
         end

         ST_MEM_WAIT: begin
            stall_raw = !(bus.mem_ack && !md_pend_q);
            if (bus.mem_ack || (cnt_q == MEM_LAST)) begin
               if (!bus.mem_ack) mem_timeout_d = 1'b1;
               md_pend_d = 1'b0;
               if (md_pend_q && MD_MULTI) begin
                  state_d = ST_MD_WAIT;
                  cnt_d   = MD_RELOAD;
               end else begin
                  state_d = ST_RUN;
                  cnt_d   = '0;
               end
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end

         default: state_d = ST_RUN;
      endcase
   end

   // Outputs are forced low while reset is asserted, independent of the inputs.
   always_comb begin
      full_stall     = stall_raw && rst;
      jump_en        = bus.ex_jump_req && !full_stall && rst;
      jump_stall     = load_use && !full_stall && !bus.ex_jump_req && rst;
      stall_cycles_d = stall_cycles_q;
      if (full_stall && (stall_cycles_q != 32'hFFFF_FFFF))
         stall_cycles_d = stall_cycles_q + 32'd1;
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q        <= ST_RUN;
         cnt_q          <= '0;
         md_pend_q      <= 1'b0;
         mem_timeout_q  <= 1'b0;
         stall_cycles_q <= '0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         md_pend_q      <= md_pend_d;
         mem_timeout_q  <= mem_timeout_d;
         stall_cycles_q <= stall_cycles_d;
      end
   end

   assign bus.full_stall   = full_stall;
   assign bus.jump_en      = jump_en;
   assign bus.jump_addr    = jump_en ? bus.ex_jump_addr : '0;
   assign bus.jump_stall   = jump_stall;
   assign bus.idex_bubble  = jump_en || jump_stall;
   assign bus.ifid_flush   = jump_en;
   assign bus.mem_timeout  = mem_timeout_q;
   assign bus.stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl: per-cycle expected vectors queued by the
// stimulus process and compared by a negedge monitor.
module tb_hazard_stall_ctrl;
   import hazard_stall_ctrl_pkg::*;

   localparam int MDL = 4;
   localparam int MTO = 8;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   hazard_stall_ctrl_if bus();

   hazard_stall_ctrl #(
      .MD_LATENCY  (MDL),
      .MEM_TIMEOUT (MTO)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct packed {
      logic        fs;
      logic        je;
      logic        js;
      logic        bub;
      logic        fl;
      logic        to;
      logic [31:0] ja;
      logic [31:0] sc;
   } obs_t;

   typedef struct {
      string name;
      obs_t  exp;
   } sb_t;

   sb_t         sb_q[$];
   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_sc = '0;

   task automatic clear_in();
      bus.id_rs1_addr  = '0;
      bus.id_rs2_addr  = '0;
      bus.id_rs1_rd    = 1'b0;
      bus.id_rs2_rd    = 1'b0;
      bus.ex_load      = 1'b0;
      bus.ex_rd_addr   = '0;
      bus.ex_jump_req  = 1'b0;
      bus.ex_jump_addr = '0;
      bus.md_start     = 1'b0;
      bus.mem_req      = 1'b0;
      bus.mem_ack      = 1'b0;
   endtask

   // Queue the expected outputs for the inputs currently driven, then advance one cycle.
   task automatic expect_cyc(input string name, input logic fs, input logic je,
                             input logic js, input logic [31:0] ja, input logic to);
      sb_t e;
      e.name    = name;
      e.exp.fs  = fs;
      e.exp.je  = je;
      e.exp.js  = js;
      e.exp.bub = je | js;
      e.exp.fl  = je;
      e.exp.to  = to;
      e.exp.ja  = ja;
      e.exp.sc  = exp_sc;
      sb_q.push_back(e);
      if (fs && (exp_sc != 32'hFFFF_FFFF)) exp_sc = exp_sc + 32'd1;
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      sb_t  e;
      obs_t got;
      if (sb_q.size() > 0) begin
         e   = sb_q.pop_front();
         got = {bus.full_stall, bus.jump_en, bus.jump_stall, bus.idex_bubble,
                bus.ifid_flush, bus.mem_timeout, bus.jump_addr, bus.stall_cycles};
         checks++;
         if (got !== e.exp) begin
            errors++;
            $display("FAIL %s got fs=%b je=%b js=%b bub=%b fl=%b to=%b ja=%h sc=%0d required fs=%b je=%b js=%b bub=%b fl=%b to=%b ja=%h sc=%0d",
                     e.name, got.fs, got.je, got.js, got.bub, got.fl, got.to, got.ja, got.sc,
                     e.exp.fs, e.exp.je, e.exp.js, e.exp.bub, e.exp.fl, e.exp.to, e.exp.ja, e.exp.sc);
         end
      end
   end

   initial begin
      #50000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      clear_in();
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Reset gates every output even with hazards presented.
      bus.md_start     = 1'b1;
      bus.mem_req      = 1'b1;
      bus.ex_jump_req  = 1'b1;
      bus.ex_jump_addr = 32'h55;
      bus.ex_load      = 1'b1;
      bus.ex_rd_addr   = 5'd3;
      bus.id_rs1_rd    = 1'b1;
      bus.id_rs1_addr  = 5'd3;
      expect_cyc("rst_gate", 0, 0, 0, 32'h0, 0);
      clear_in();
      rst = 1'b1;
      expect_cyc("idle", 0, 0, 0, 32'h0, 0);

      // Load-use
      bus.ex_load     = 1'b1;
      bus.ex_rd_addr  = 5'd5;
      bus.id_rs1_rd   = 1'b1;
      bus.id_rs1_addr = 5'd5;
      expect_cyc("lu_rs1", 0, 0, 1, 32'h0, 0);
      bus.ex_rd_addr  = 5'd0;
      bus.id_rs1_addr = 5'd0;
      expect_cyc("lu_x0", 0, 0, 0, 32'h0, 0);
      bus.ex_rd_addr  = 5'd7;
      bus.id_rs1_rd   = 1'b0;
      bus.id_rs1_addr = 5'd7;
      bus.id_rs2_rd   = 1'b1;
      bus.id_rs2_addr = 5'd7;
      expect_cyc("lu_rs2", 0, 0, 1, 32'h0, 0);
      bus.id_rs2_rd   = 1'b0;
      expect_cyc("lu_noread", 0, 0, 0, 32'h0, 0);
      bus.id_rs2_rd    = 1'b1;
      bus.ex_jump_req  = 1'b1;
      bus.ex_jump_addr = 32'h200;
      expect_cyc("jump_over_lu", 0, 1, 0, 32'h200, 0);
      clear_in();

      // Mul/div: 4 stall cycles total, md_start ignored mid-wait
      bus.md_start = 1'b1;
      expect_cyc("md_start", 1, 0, 0, 32'h0, 0);
      bus.md_start = 1'b0;
      expect_cyc("md_w2", 1, 0, 0, 32'h0, 0);
      bus.md_start = 1'b1;
      expect_cyc("md_w1_ign", 1, 0, 0, 32'h0, 0);
      bus.md_start = 1'b0;
      expect_cyc("md_w0", 1, 0, 0, 32'h0, 0);
      expect_cyc("md_done_sc4", 0, 0, 0, 32'h0, 0);

      // Memory wait, ack on third cycle; jump in the ack cycle is not stalled
      bus.mem_req = 1'b1;
      expect_cyc("mem_req", 1, 0, 0, 32'h0, 0);
      expect_cyc("mem_wait", 1, 0, 0, 32'h0, 0);
      bus.mem_ack      = 1'b1;
      bus.ex_jump_req  = 1'b1;
      bus.ex_jump_addr = 32'h300;
      expect_cyc("mem_ack_jump", 0, 1, 0, 32'h300, 0);
      clear_in();
      expect_cyc("mem_idle", 0, 0, 0, 32'h0, 0);

      // Memory wait with coincident md_start: MD_WAIT follows the ack
      bus.mem_req  = 1'b1;
      bus.md_start = 1'b1;
      expect_cyc("mem_md", 1, 0, 0, 32'h0, 0);
      bus.md_start = 1'b0;
      expect_cyc("mem_md_wait", 1, 0, 0, 32'h0, 0);
      bus.mem_ack = 1'b1;
      expect_cyc("mem_ack_pend", 1, 0, 0, 32'h0, 0);
      clear_in();
      for (int i = 0; i < MDL - 1; i++) expect_cyc("pend_md_wait", 1, 0, 0, 32'h0, 0);
      expect_cyc("pend_done", 0, 0, 0, 32'h0, 0);

      // Jump held by EX during MD_WAIT, taken on first free cycle
      bus.md_start     = 1'b1;
      bus.ex_jump_req  = 1'b1;
      bus.ex_jump_addr = 32'h100;
      expect_cyc("jmp_md_start", 1, 0, 0, 32'h0, 0);
      bus.md_start = 1'b0;
      for (int i = 0; i < MDL - 1; i++) expect_cyc("jmp_md_wait", 1, 0, 0, 32'h0, 0);
      expect_cyc("jmp_release", 0, 1, 0, 32'h100, 0);
      clear_in();
      expect_cyc("jmp_clear", 0, 0, 0, 32'h0, 0);

      // Watchdog: entry cycle plus MTO MEM_WAIT cycles, then forced release
      bus.mem_req = 1'b1;
      expect_cyc("to_enter", 1, 0, 0, 32'h0, 0);
      for (int i = 0; i < MTO; i++) expect_cyc("to_wait", 1, 0, 0, 32'h0, 0);
      bus.mem_req = 1'b0;
      expect_cyc("to_release", 0, 0, 0, 32'h0, 1);
      bus.mem_req = 1'b1;
      bus.mem_ack = 1'b1;
      expect_cyc("to_sticky", 0, 0, 0, 32'h0, 1);
      clear_in();

      // Asynchronous reset in the middle of MD_WAIT
      bus.md_start = 1'b1;
      expect_cyc("md_pre", 1, 0, 0, 32'h0, 1);
      bus.md_start = 1'b0;
      expect_cyc("md_pre_wait", 1, 0, 0, 32'h0, 1);
      #2;
      rst              = 1'b0;
      bus.ex_jump_req  = 1'b1;
      bus.ex_jump_addr = 32'h44;
      exp_sc           = '0;
      expect_cyc("rst_mid", 0, 0, 0, 32'h0, 0);
      expect_cyc("rst_hold", 0, 0, 0, 32'h0, 0);
      clear_in();
      rst = 1'b1;
      expect_cyc("post_rst_idle", 0, 0, 0, 32'h0, 0);

      repeat (2) @(negedge clk);
      if (sb_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain got %0d pending entries required 0", sb_q.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
